// File: rtl/ext_mem_ctrl.sv
// External-memory responder for the microprocessor_system ext_mem bus.
// RAM with programmable wait states, write-protect window, preload port and saturating counters.
module ext_mem_ctrl #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    WAIT_STATES = 1,
  parameter logic [ADDR_WIDTH-1:0] WP_BASE     = 16'h8000,
  parameter logic [ADDR_WIDTH-1:0] WP_LIMIT    = 16'h8FFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ext_mem_addr,
  inout  wire  [DATA_WIDTH-1:0] ext_mem_data,
  input  logic                  ext_mem_read,
  input  logic                  ext_mem_write,
  input  logic                  ext_mem_cs,
  output logic                  ext_mem_ready,
  input  logic                  wp_enable,
  output logic                  wp_fault,
  output logic                  bus_error,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_data,
  output logic                  init_busy,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] CNT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  function automatic logic in_wp_window(input logic [ADDR_WIDTH-1:0] a);
    return (a >= WP_BASE) && (a <= WP_LIMIT);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  state_t                state, state_nx;
  logic [3:0]            cnt_p0;
  logic [ADDR_WIDTH-1:0] req_addr_p0;
  logic [DATA_WIDTH-1:0] req_wdata_p0;
  logic                  req_rd_p0, req_err_p0, req_wp_p0;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  wp_drop_p1;
  logic                  rd_oe;

  logic                  accept, enter_done;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic                  cur_rd, cur_wp, cur_drop;
  logic                  mem_we, init_wr;

  assign accept = (state == S_IDLE) && ext_mem_cs && (ext_mem_read || ext_mem_write);

  // With zero wait states the memory op happens on the acceptance edge, so the
  // op is taken straight from the bus in IDLE and from the latched copy otherwise.
  assign cur_addr  = (state == S_IDLE) ? ext_mem_addr : req_addr_p0;
  assign cur_wdata = (state == S_IDLE) ? ext_mem_data : req_wdata_p0;
  assign cur_rd    = (state == S_IDLE) ? ext_mem_read : req_rd_p0;
  assign cur_wp    = (state == S_IDLE) ? wp_enable    : req_wp_p0;
  assign cur_drop  = !cur_rd && cur_wp && in_wp_window(cur_addr);

  assign enter_done = (state_nx == S_DONE) && (state != S_DONE);
  assign mem_we     = enter_done && !cur_rd && !cur_drop && !rst;
  assign init_wr    = (state == S_IDLE) && !accept && init_we && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = HAS_WAIT ? S_WAIT : S_DONE;
      S_WAIT:  if (cnt_p0 == 4'd0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ext_mem_ready = 1'b0;
    wp_fault      = 1'b0;
    bus_error     = 1'b0;
    rd_oe         = 1'b0;
    init_busy     = (state != S_IDLE);
    if (state == S_DONE) begin
      ext_mem_ready = 1'b1;
      wp_fault      = wp_drop_p1;
      bus_error     = req_err_p0;
      rd_oe         = req_rd_p0;
    end
  end

  assign ext_mem_data = rd_oe ? rd_data_p1 : {DATA_WIDTH{1'bz}};

  // Request capture: control flags carry reset, address/data do not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0     <= 4'd0;
      req_rd_p0  <= 1'b0;
      req_err_p0 <= 1'b0;
      req_wp_p0  <= 1'b0;
      wp_drop_p1 <= 1'b0;
    end else begin
      if (accept) begin
        cnt_p0     <= CNT_LOAD;
        req_rd_p0  <= ext_mem_read;
        req_err_p0 <= ext_mem_read && ext_mem_write;
        req_wp_p0  <= wp_enable;
      end else if (state == S_WAIT) begin
        cnt_p0 <= cnt_p0 - 4'd1;
      end
      if (enter_done) wp_drop_p1 <= cur_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr_p0  <= ext_mem_addr;
      req_wdata_p0 <= ext_mem_data;
    end
  end

  // Memory access stage: commit or fetch on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (mem_we)       mem[cur_addr]  <= cur_wdata;
    else if (init_wr) mem[init_addr] <= init_data;
    if (enter_done && cur_rd) rd_data_p1 <= mem[cur_addr];
  end

  // Counter stage: counts land as the DONE cycle retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (state == S_DONE) begin
      if (req_rd_p0)        rd_count <= sat_inc(rd_count);
      else if (!wp_drop_p1) wr_count <= sat_inc(wr_count);
    end
  end

endmodule

// File: tb/tb_ext_mem_ctrl.sv
// Directed bench for ext_mem_ctrl: one instance with one wait state, one with none.
module tb_ext_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] addr;
  logic        rd, wr, cs, wp_en;
  logic        init_we;
  logic [15:0] init_addr;
  logic [7:0]  init_data;
  logic [7:0]  tb_wdata;
  logic        tb_drv;
  wire  [7:0]  data_bus;
  logic        ready, wp_fault, bus_error, init_busy;
  logic [15:0] rd_count, wr_count;

  assign data_bus = tb_drv ? tb_wdata : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_bus[g]);
  end

  ext_mem_ctrl #(.WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst),
    .ext_mem_addr(addr), .ext_mem_data(data_bus),
    .ext_mem_read(rd), .ext_mem_write(wr), .ext_mem_cs(cs),
    .ext_mem_ready(ready), .wp_enable(wp_en), .wp_fault(wp_fault),
    .bus_error(bus_error), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data), .init_busy(init_busy),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  logic [15:0] c0_addr;
  logic        c0_rd, c0_wr, c0_cs, c0_wp, c0_iwe;
  logic [15:0] c0_iaddr;
  logic [7:0]  c0_idata;
  wire  [7:0]  bus0;
  logic        c0_ready, c0_wpf, c0_berr, c0_busy;
  logic [15:0] c0_rdc, c0_wrc;

  ext_mem_ctrl #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .ext_mem_addr(c0_addr), .ext_mem_data(bus0),
    .ext_mem_read(c0_rd), .ext_mem_write(c0_wr), .ext_mem_cs(c0_cs),
    .ext_mem_ready(c0_ready), .wp_enable(c0_wp), .wp_fault(c0_wpf),
    .bus_error(c0_berr), .init_we(c0_iwe), .init_addr(c0_iaddr),
    .init_data(c0_idata), .init_busy(c0_busy),
    .rd_count(c0_rdc), .wr_count(c0_wrc)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int         r_lat;
  logic [7:0] r_data, r_pbus;
  logic       r_wpf, r_berr, r_busy, r_prdy, r_pwpf, r_pberr;

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    init_we = 1'b1; init_addr = a; init_data = d;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  // One bus transaction on u_dut; iw also holds a colliding preload to 0x2000.
  task automatic do_req(input logic [15:0] a, input logic [7:0] d,
                        input logic r, input logic w, input logic wp, input logic iw);
    @(negedge clk);
    addr = a; tb_wdata = d; tb_drv = w && !r;
    rd = r; wr = w; cs = 1'b1; wp_en = wp;
    if (iw) begin
      init_we = 1'b1; init_addr = 16'h2000; init_data = 8'h55;
    end
    @(posedge clk);
    r_lat = 0; r_data = 8'h00; r_wpf = 1'b0; r_berr = 1'b0; r_busy = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cs = 1'b0; rd = 1'b0; wr = 1'b0; tb_drv = 1'b0; wp_en = 1'b0;
        r_busy = init_busy;
      end
      if (ready) begin
        r_lat = i; r_data = data_bus; r_wpf = wp_fault; r_berr = bus_error;
        break;
      end
    end
    init_we = 1'b0;
    @(negedge clk);
    r_pbus = data_bus; r_prdy = ready; r_pwpf = wp_fault; r_pberr = bus_error;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] pat;
    int          seen;
    rst = 1'b1; addr = '0; rd = 0; wr = 0; cs = 0; wp_en = 0;
    init_we = 0; init_addr = '0; init_data = '0; tb_wdata = '0; tb_drv = 0;
    c0_addr = '0; c0_rd = 0; c0_wr = 0; c0_cs = 0; c0_wp = 0;
    c0_iwe = 0; c0_iaddr = '0; c0_idata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_wpf", wp_fault, 1'b0);
    chk("rst_berr", bus_error, 1'b0);
    chk("rst_rdc", rd_count, 16'd0);
    chk("rst_wrc", wr_count, 16'd0);
    chk("rst_busy", init_busy, 1'b0);
    chk("rst_bus", data_bus, 8'hFF);
    rst = 1'b0;

    preload(16'h8000, 8'h04);
    preload(16'h8010, 8'h5A);
    preload(16'h8FFF, 8'h66);
    preload(16'h1001, 8'hAA);
    preload(16'h2000, 8'h10);

    do_req(16'h8000, 8'h00, 1, 0, 0, 0);
    chk("t1_lat", r_lat, 2);
    chk("t1_busy", r_busy, 1'b1);
    chk("t1_data", r_data, 8'h04);
    chk("t1_post_bus", r_pbus, 8'hFF);
    chk("t1_post_rdy", r_prdy, 1'b0);
    chk("t1_rdc", rd_count, 16'd1);

    do_req(16'h1000, 8'h34, 0, 1, 0, 0);
    chk("t2_lat", r_lat, 2);
    chk("t2_wpf", r_wpf, 1'b0);
    chk("t2_wrc", wr_count, 16'd1);
    do_req(16'h1000, 8'h00, 1, 0, 0, 0);
    chk("t2_data", r_data, 8'h34);
    chk("t2_rdc", rd_count, 16'd2);

    do_req(16'h8010, 8'hFF, 0, 1, 1, 0);
    chk("t3_wpf", r_wpf, 1'b1);
    chk("t3_post_wpf", r_pwpf, 1'b0);
    chk("t3_wrc", wr_count, 16'd1);
    do_req(16'h8010, 8'h00, 1, 0, 0, 0);
    chk("t3_keep", r_data, 8'h5A);
    do_req(16'h9000, 8'hFF, 0, 1, 1, 0);
    chk("t3_out_wpf", r_wpf, 1'b0);
    chk("t3_out_wrc", wr_count, 16'd2);
    do_req(16'h9000, 8'h00, 1, 0, 0, 0);
    chk("t3_out_data", r_data, 8'hFF);
    do_req(16'h8FFF, 8'h11, 0, 1, 1, 0);
    chk("t3_limit_wpf", r_wpf, 1'b1);
    do_req(16'h8FFF, 8'h00, 1, 0, 0, 0);
    chk("t3_limit_data", r_data, 8'h66);
    do_req(16'h7FFF, 8'h22, 0, 1, 1, 0);
    chk("t3_below_wpf", r_wpf, 1'b0);
    do_req(16'h7FFF, 8'h00, 1, 0, 0, 0);
    chk("t3_below_data", r_data, 8'h22);
    do_req(16'h8010, 8'h77, 0, 1, 0, 0);
    chk("t3_wpoff_wpf", r_wpf, 1'b0);
    do_req(16'h8010, 8'h00, 1, 0, 0, 0);
    chk("t3_wpoff_data", r_data, 8'h77);
    chk("t3_wrc_end", wr_count, 16'd4);
    chk("t3_rdc_end", rd_count, 16'd7);

    do_req(16'h1000, 8'h99, 1, 1, 0, 1);
    chk("t4_berr", r_berr, 1'b1);
    chk("t4_data", r_data, 8'h34);
    chk("t4_post_berr", r_pberr, 1'b0);
    chk("t4_wrc", wr_count, 16'd4);
    chk("t4_rdc", rd_count, 16'd8);
    do_req(16'h2000, 8'h00, 1, 0, 0, 0);
    chk("t4_init_drop", r_data, 8'h10);

    @(negedge clk);
    addr = 16'h1000; cs = 1'b1;
    @(negedge clk);
    chk("cs_only_busy", init_busy, 1'b0);
    @(negedge clk);
    chk("cs_only_ready", ready, 1'b0);
    cs = 1'b0;

    @(negedge clk);
    addr = 16'h1001; tb_wdata = 8'hBB; tb_drv = 1; wr = 1; cs = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_busy_pre", init_busy, 1'b1);
    cs = 0; wr = 0; tb_drv = 0;
    rst = 1'b1;
    #1;
    chk("t5_ready", ready, 1'b0);
    chk("t5_busy", init_busy, 1'b0);
    chk("t5_rdc", rd_count, 16'd0);
    chk("t5_wrc", wr_count, 16'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    rst = 1'b0;
    chk("t5_no_ready", seen, 0);
    do_req(16'h1001, 8'h00, 1, 0, 0, 0);
    chk("t5_keep", r_data, 8'hAA);
    chk("t5_rdc_after", rd_count, 16'd1);

    @(negedge clk);
    c0_addr = 16'h0040; c0_rd = 1'b1; c0_cs = 1'b1; pat = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pat[i] = c0_ready;
    end
    c0_cs = 1'b0; c0_rd = 1'b0;
    chk("t6_pattern", pat, 20'h55555);
    chk("t6_ready_cnt", $countones(pat), 10);
    chk("t6_rdc", c0_rdc, 16'd10);

    force u_dut0.rd_count = 16'hFFFE;
    @(negedge clk);
    release u_dut0.rd_count;
    #1;
    chk("t6_forced", c0_rdc, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      c0_cs = 1'b1; c0_rd = 1'b1;
      @(negedge clk);
      chk("t6_sat_ready", c0_ready, 1'b1);
      c0_cs = 1'b0; c0_rd = 1'b0;
      @(negedge clk);
      chk("t6_sat_rdc", c0_rdc, 16'hFFFF);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_mem_ctrl.md
Name: ext_mem_ctrl

Overview:
Synthesizable external-memory responder sitting directly downstream of microprocessor_system on its ext_mem bus (addr/data/read/write/cs/ready). Holds a 2^ADDR_WIDTH x DATA_WIDTH RAM and answers each bus request after a programmable number of wait states with a one-cycle ready pulse. Adds a write-protect window (program image at 0x8000), protocol-error detection, a side-band preload port for bench/boot image loading, and saturating access counters.

Parameters:
ADDR_WIDTH, 16, bus address width; RAM depth = 2^ADDR_WIDTH
DATA_WIDTH, 8, bus data width
WAIT_STATES, 1, extra cycles inserted before ready; legal range 0..15
WP_BASE, 16'h8000, first write-protected address (inclusive)
WP_LIMIT, 16'h8FFF, last write-protected address (inclusive)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
ext_mem_addr  in  ADDR_WIDTH  request address
ext_mem_data  inout  DATA_WIDTH  write data in; read data driven out only during read ready cycle, else Z
ext_mem_read  in  1  read request
ext_mem_write  in  1  write request
ext_mem_cs  in  1  chip select; request valid only when high
ext_mem_ready  out  1  one-cycle completion pulse
wp_enable  in  1  enables the write-protect window
wp_fault  out  1  pulses with ready when a write was dropped by protection
bus_error  out  1  pulses with ready when read and write were both high at acceptance
init_we  in  1  preload write strobe
init_addr  in  ADDR_WIDTH  preload address
init_data  in  DATA_WIDTH  preload data
init_busy  out  1  high whenever state != IDLE; preload ignored while high
rd_count  out  16  completed reads, saturates at 16'hFFFF
wr_count  out  16  committed writes (not dropped), saturates at 16'hFFFF

Behaviour:
- Reset (async, any state): state=IDLE, ext_mem_ready=0, wp_fault=0, bus_error=0, rd_count=0, wr_count=0, data bus Z, wait counter=0. RAM contents NOT cleared. Reset mid-transaction aborts it; a pending write is not committed.
- FSM states: IDLE, WAIT, DONE.
- IDLE: if ext_mem_cs && (read||write) at a rising edge -> latch addr, write data, op; go WAIT if WAIT_STATES>0 else DONE; load counter with WAIT_STATES-1. Else if init_we -> RAM[init_addr]<=init_data, stay IDLE. A bus request takes priority over init_we in the same cycle; the init write is dropped.
- WAIT: decrement counter; at 0 go DONE. Request inputs ignored (master must hold them; changes are not observed).
- Transition into DONE: read -> rd_data<=RAM[latched addr]; write -> commit RAM unless wp_enable && WP_BASE<=addr<=WP_LIMIT (then drop, set wp_fault).
- DONE (exactly one cycle): ext_mem_ready=1; drive ext_mem_data=rd_data iff latched op is read; wp_fault/bus_error valid this cycle only; counters increment at exit. Next state IDLE unconditionally.
- Latency: acceptance edge -> ready high for cycle 1+WAIT_STATES after it; WAIT_STATES=0 gives ready the cycle after acceptance. Back-to-back: cs held high -> new request accepted in IDLE cycle after DONE (throughput 1 per WAIT_STATES+2 cycles).
- read && write both high at acceptance: performed as read, bus_error=1 in DONE, wr_count unchanged.
- cs high with neither read nor write: no transaction, stays IDLE.
- wp_enable sampled at acceptance edge (latched with request).
- Counters saturate, never wrap.

Test Plan:
- Preload 0x8000=0x04 via init port, WAIT_STATES=1; read 0x8000 -> ready exactly 2 cycles after acceptance, data bus=0x04 during ready only, Z otherwise, rd_count=1.
- Write 0x34 to 0x1000, then read 0x1000 -> read returns 0x34, wr_count=1, wp_fault=0.
- wp_enable=1, write 0xFF to 0x8010 -> ready pulses with wp_fault=1, later read 0x8010 returns preloaded value, wr_count unchanged; same write to 0x9000 commits.
- read=write=1 at 0x1000 -> treated as read, bus_error=1 for the ready cycle only, wr_count unchanged.
- Assert rst during WAIT of a write to 0x1001 (pre-content 0xAA) -> ready never pulses, outputs return to reset values immediately, 0x1001 still 0xAA.
- Hold cs+read for 20 cycles with WAIT_STATES=0 -> ready every 2nd cycle, rd_count=10; force rd_count to 0xFFFE then 3 reads -> stays 0xFFFF.
